led_matrix_scroller: RTL and testbench

LED_MATRIX_SCROLLER -- requirements
Module: led_matrix_scroller

---
 rtl/led_matrix_scroller.sv | 141 ++++++++++++++
 tb/tb_led_matrix_scroller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scroller.sv
// Column-multiplexed LED matrix driver that scans a window of COLS font columns
// out of a MSG_LEN-column message ROM and scrolls that window every SCROLL_FRAMES frames.
module led_matrix_scroller #(
  parameter int TICK_DIV      = 25000,
  parameter int COLS          = 8,
  parameter int ROW_W         = 10,
  parameter int MSG_LEN       = 32,
  parameter int SCROLL_FRAMES = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       dir,
  output logic [$clog2(MSG_LEN)-1:0] rom_adr,
  input  logic [ROW_W-1:0]           rom_dat,
  output logic [COLS-1:0]            col_sel,
  output logic [ROW_W-1:0]           row_dat,
  output logic                       frame_done
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int SW = AW + 1;
  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(SCROLL_FRAMES + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_FRAMES - 1);
  localparam logic [AW-1:0] MSG_LAST  = AW'(MSG_LEN - 1);
  localparam logic [SW-1:0] MSG_MOD   = SW'(MSG_LEN);

  typedef enum logic [1:0] {IDLE, BLANK, LATCH, SHOW} state_t;

  state_t             state, state_n;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [CW-1:0]      col, col_n;
  logic [FW-1:0]      frm, frm_n;
  logic [AW-1:0]      offset, offset_n;
  logic [AW-1:0]      rom_adr_n;
  logic [ROW_W-1:0]   row_dat_n;
  logic [COLS-1:0]    col_sel_n;
  logic               frame_done_n;

  // Both operands are below MSG_LEN, so a single conditional subtract
  // gives the modulus even when MSG_LEN is not a power of two.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [SW-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= MSG_MOD) s = s - MSG_MOD;
    return s[AW-1:0];
  endfunction

  assign tick = en && (tick_cnt == TICK_LAST);

  // Scan tick prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             tick_cnt <= '0;
    else if (!en || tick_cnt == TICK_LAST)  tick_cnt <= '0;
    else                                    tick_cnt <= tick_cnt + TW'(1);
  end

  // Scan sequencer: next state and output decode
  always_comb begin
    state_n      = state;
    col_n        = col;
    frm_n        = frm;
    offset_n     = offset;
    rom_adr_n    = rom_adr;
    row_dat_n    = row_dat;
    col_sel_n    = '1;
    frame_done_n = 1'b0;
    if (!en) begin
      state_n   = IDLE;
      col_n     = '0;
      frm_n     = '0;
      row_dat_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) state_n = BLANK;
        end
        BLANK: begin
          rom_adr_n = wrap_add(offset, AW'(col));
          state_n   = LATCH;
        end
        LATCH: begin
          row_dat_n = rom_dat;
          col_sel_n = ~(COLS'(1) << col);
          state_n   = SHOW;
        end
        SHOW: begin
          col_sel_n = ~(COLS'(1) << col);
          if (tick) begin
            col_sel_n = '1;
            state_n   = BLANK;
            if (col == COL_LAST) begin
              col_n        = '0;
              frame_done_n = 1'b1;
              if (frm == FRM_LAST) begin
                frm_n    = '0;
                offset_n = dir ? ((offset == '0) ? MSG_LAST : offset - AW'(1))
                               : wrap_add(offset, AW'(1));
              end else begin
                frm_n = frm + FW'(1);
              end
            end else begin
              col_n = col + CW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Registered state and outputs; reset blanks the matrix without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      frm        <= '0;
      offset     <= '0;
      rom_adr    <= '0;
      row_dat    <= '0;
      col_sel    <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      frm        <= frm_n;
      offset     <= offset_n;
      rom_adr    <= rom_adr_n;
      row_dat    <= row_dat_n;
      col_sel    <= col_sel_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_led_matrix_scroller.sv
// Directed, table-driven bench for led_matrix_scroller with a 4x10 matrix,
// an 8-column message ROM (ROM[i] = 10'h100 + i) and a 2-frame scroll period.
module tb_led_matrix_scroller;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [2:0] rom_adr;
  logic [9:0] rom_dat;
  logic [3:0] col_sel;
  logic [9:0] row_dat;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int fd_cnt = 0;

  typedef struct {
    int         at;
    logic       en;
    logic       dir;
    logic [3:0] cs;
    logic [9:0] row;
    logic [2:0] adr;
    logic       fd;
  } vec_t;

  vec_t vecs[$];

  led_matrix_scroller #(
    .TICK_DIV(8), .COLS(4), .ROW_W(10), .MSG_LEN(8), .SCROLL_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
    .rom_adr(rom_adr), .rom_dat(rom_dat),
    .col_sel(col_sel), .row_dat(row_dat), .frame_done(frame_done)
  );

  assign rom_dat = 10'h100 + {7'd0, rom_adr};

  always #5 if (clk_run) clk = ~clk;

  always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s v%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (n < target) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic add(input int at, input logic e, input logic d, input logic [3:0] cs,
                     input logic [9:0] row, input logic [2:0] adr, input logic fd);
    vec_t v;
    v.at = at; v.en = e; v.dir = d; v.cs = cs; v.row = row; v.adr = adr; v.fd = fd;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    dir   = 1'b0;

    // edge, en, dir, col_sel, row_dat, rom_adr, frame_done (edges counted from reset release)
    add(  7, 1, 0, 4'hF, 10'h000, 3'd0, 0);
    add(  8, 1, 0, 4'hF, 10'h000, 3'd0, 0);
    add(  9, 1, 0, 4'hF, 10'h000, 3'd0, 0);
    add( 10, 1, 0, 4'hE, 10'h100, 3'd0, 0);
    add( 15, 1, 0, 4'hE, 10'h100, 3'd0, 0);
    add( 16, 1, 0, 4'hF, 10'h100, 3'd0, 0);
    add( 17, 1, 0, 4'hF, 10'h100, 3'd1, 0);
    add( 18, 1, 0, 4'hD, 10'h101, 3'd1, 0);
    add( 26, 1, 0, 4'hB, 10'h102, 3'd2, 0);
    add( 34, 1, 0, 4'h7, 10'h103, 3'd3, 0);
    add( 39, 1, 0, 4'h7, 10'h103, 3'd3, 0);
    add( 40, 1, 0, 4'hF, 10'h103, 3'd3, 1);
    add( 41, 1, 0, 4'hF, 10'h103, 3'd0, 0);
    add( 42, 1, 0, 4'hE, 10'h100, 3'd0, 0);
    add( 72, 1, 0, 4'hF, 10'h103, 3'd3, 1);
    add( 73, 1, 0, 4'hF, 10'h103, 3'd1, 0);
    add( 74, 1, 0, 4'hE, 10'h101, 3'd1, 0);
    add( 82, 1, 0, 4'hD, 10'h102, 3'd2, 0);
    add(418, 1, 0, 4'h7, 10'h101, 3'd1, 0);
    add(426, 1, 0, 4'hE, 10'h106, 3'd6, 0);
    add(458, 1, 0, 4'hE, 10'h107, 3'd7, 0);
    add(466, 1, 0, 4'hD, 10'h100, 3'd0, 0);
    add(522, 1, 0, 4'hE, 10'h100, 3'd0, 0);
    add(538, 1, 1, 4'hB, 10'h102, 3'd2, 0);
    add(584, 1, 1, 4'hF, 10'h103, 3'd3, 1);
    add(586, 1, 1, 4'hE, 10'h107, 3'd7, 0);
    add(594, 1, 1, 4'hD, 10'h100, 3'd0, 0);
    add(650, 1, 1, 4'hE, 10'h106, 3'd6, 0);
    add(666, 1, 1, 4'hB, 10'h100, 3'd0, 0);
    add(667, 0, 1, 4'hF, 10'h000, 3'd0, 0);
    add(668, 1, 1, 4'hF, 10'h000, 3'd0, 0);
    add(676, 1, 1, 4'hF, 10'h000, 3'd6, 0);
    add(677, 1, 1, 4'hE, 10'h106, 3'd6, 0);
    add(685, 1, 1, 4'hD, 10'h107, 3'd7, 0);
    add(707, 1, 1, 4'hF, 10'h101, 3'd1, 1);
    add(708, 1, 1, 4'hF, 10'h101, 3'd6, 0);
    add(738, 1, 1, 4'h7, 10'h101, 3'd1, 0);
    add(739, 0, 1, 4'hF, 10'h000, 3'd1, 0);
    add(748, 1, 1, 4'hF, 10'h000, 3'd6, 0);
    add(749, 1, 1, 4'hE, 10'h106, 3'd6, 0);

    // Reset with the clock stopped
    #1 rst_n = 1'b0;
    #2;
    chk("rst_col_sel", 0, col_sel, 4'hF);
    chk("rst_row_dat", 0, row_dat, 10'h000);
    chk("rst_rom_adr", 0, rom_adr, 3'd0);
    chk("rst_frame_done", 0, frame_done, 1'b0);

    clk_run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    n     = 0;

    foreach (vecs[i]) begin
      en  = vecs[i].en;
      dir = vecs[i].dir;
      step_to(vecs[i].at);
      chk("col_sel", i, col_sel, vecs[i].cs);
      chk("row_dat", i, row_dat, vecs[i].row);
      chk("rom_adr", i, rom_adr, vecs[i].adr);
      chk("frame_done", i, frame_done, vecs[i].fd);
    end

    // 20 wraps before the disable, one after resuming, none on the suppressed wrap
    chk("frame_done_pulses", 0, fd_cnt, 21);

    // Asynchronous reset in the middle of a SHOW phase, between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_col_sel", 0, col_sel, 4'hF);
    chk("async_row_dat", 0, row_dat, 10'h000);
    chk("async_rom_adr", 0, rom_adr, 3'd0);
    chk("async_frame_done", 0, frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    dir   = 1'b0;
    n     = 0;
    step_to(1);
    chk("post_rst_col_sel", 1, col_sel, 4'hF);
    step_to(9);
    chk("post_rst_rom_adr", 9, rom_adr, 3'd0);
    chk("post_rst_blank", 9, col_sel, 4'hF);
    step_to(10);
    chk("post_rst_col_sel", 10, col_sel, 4'hE);
    chk("post_rst_row_dat", 10, row_dat, 10'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
